wb_pwm_cfg_master: RTL and testbench

Wishbone classic single-write initiator that drives the PWM/timer peripheral's Wishbone slave port. A host-side valid/ready command interface feeds a small command FIFO. Each queued (address, data) pair becomes one Wishbone write cycle. Each cycle ends either on slave acknowledge or on a bounded timeout, so register programming sequences (ctrl, divisor, period, duty) can be issued back-to-back without the host tracking bus handshakes.

---
 rtl/wb_pwm_cfg_master.sv | 121 ++++++++++++
 tb/tb_wb_pwm_cfg_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pwm_cfg_master.sv
// rtl/wb_pwm_cfg_master.sv - queued Wishbone single-write initiator for the PWM/timer register block
module wb_pwm_cfg_master #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ADDR_W-1:0] i_cmd_adr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_adr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_err_adr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d, err_d, pop;

  logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic                     full, empty, push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = i_cmd_valid && !full;

  assign o_cmd_ready = !full;
  assign o_busy      = !empty || (state_q == S_BUS);
  assign o_wb_cyc    = (state_q == S_BUS);
  assign o_wb_stb    = o_wb_cyc;
  assign o_wb_we     = o_wb_cyc;

  // Command storage; pointers alone define validity, so the array needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {i_cmd_adr, i_cmd_data};
  end

  // FIFO pointers; push and pop may both happen in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Next state: pop only from IDLE, ack beats timeout on the same edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (i_wb_ack) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, wait counter, bus address/data and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      o_wb_adr  <= '0;
      o_wb_data <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_err_adr <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_done  <= done_d;
      o_err   <= err_d;
      if (pop) {o_wb_adr, o_wb_data} <= mem[rd_ptr[AW-1:0]];
      if (err_d) o_err_adr <= o_wb_adr;
    end
  end

endmodule

// File: tb/tb_wb_pwm_cfg_master.sv
// tb/tb_wb_pwm_cfg_master.sv - randomized check of wb_pwm_cfg_master against a transaction-level model
module tb_wb_pwm_cfg_master;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int TMO    = 16;

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_data;
  logic              wb_cyc, wb_stb, wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ack;
  logic              busy, done, err;
  logic [ADDR_W-1:0] err_adr;

  wb_pwm_cfg_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_adr(cmd_adr), .i_cmd_data(cmd_data),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_adr(wb_adr), .o_wb_data(wb_data), .i_wb_ack(wb_ack),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_adr(err_adr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued commands, one transaction in flight with its age in bus cycles.
  logic [31:0]       exp_q[$];
  bit                m_bus;
  int                m_cnt;
  int                ack_at;
  int                force_ack_at = -1;
  logic [ADDR_W-1:0] cur_adr, m_err_adr;
  logic [DATA_W-1:0] cur_data;
  bit                m_done, m_err;

  task automatic model_reset();
    exp_q.delete();
    m_bus = 0; m_cnt = 0; m_done = 0; m_err = 0; m_err_adr = '0;
  endtask

  task automatic pick_ack();
    int r;
    if (force_ack_at >= 0) begin
      ack_at = force_ack_at;
      force_ack_at = -1;
    end else begin
      r = $urandom_range(9);
      if (r < 5)       ack_at = 2;
      else if (r < 7)  ack_at = $urandom_range(TMO, 1);
      else if (r == 7) ack_at = TMO;
      else             ack_at = TMO + 50;
    end
  endtask

  task automatic drive_ack();
    if (m_bus) wb_ack = (m_cnt == ack_at);
    else       wb_ack = ($urandom_range(7) == 0);
  endtask

  task automatic check_outputs();
    check("cyc", wb_cyc, m_bus);
    check("stb", wb_stb, m_bus);
    check("we", wb_we, m_bus);
    check("done", done, m_done);
    check("err", err, m_err);
    check("err_adr", err_adr, m_err_adr);
    check("ready", cmd_ready, exp_q.size() < DEPTH);
    check("busy", busy, (exp_q.size() > 0) || m_bus);
    if (m_bus) begin
      check("wb_adr", wb_adr, cur_adr);
      check("wb_data", wb_data, cur_data);
    end
  endtask

  task automatic cycle(output bit pushed);
    bit          ack_now;
    logic [31:0] cmd;
    pushed  = cmd_valid && (exp_q.size() < DEPTH);
    cmd     = {cmd_adr, cmd_data};
    ack_now = wb_ack;
    @(posedge clk);
    m_done = 0;
    m_err  = 0;
    if (m_bus) begin
      if (ack_now) begin
        m_bus = 0; m_done = 1;
      end else if (m_cnt == TMO) begin
        m_bus = 0; m_err = 1; m_err_adr = cur_adr;
      end else begin
        m_cnt++;
      end
    end else if (exp_q.size() > 0) begin
      {cur_adr, cur_data} = exp_q.pop_front();
      m_bus = 1;
      m_cnt = 1;
      pick_ack();
    end
    if (pushed) exp_q.push_back(cmd);
    #1;
    check_outputs();
    drive_ack();
  endtask

  task automatic run_idle(input int n);
    bit p;
    cmd_valid = 1'b0;
    repeat (n) cycle(p);
  endtask

  task automatic push_wait(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit p;
    int guard;
    p = 0;
    guard = 0;
    cmd_adr = a;
    cmd_data = d;
    cmd_valid = 1'b1;
    while (!p && guard < 100) begin
      cycle(p);
      guard++;
    end
    if (!p) check("push_accept", 0, 1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    bit p;
    int guard;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_adr = '0; cmd_data = '0; wb_ack = 1'b0;
    model_reset();
    #12;
    check("rst_cyc", wb_cyc, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_adr", err_adr, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    #1;
    check("rst_ready", cmd_ready, 1);

    // Single write with a registered-ack slave.
    force_ack_at = 2;
    push_wait(16'h0000, 16'h0016);
    run_idle(6);

    // Timeout with no ack, then a normal follow-up command.
    force_ack_at = TMO + 50;
    push_wait(16'h0006, 16'h0123);
    push_wait(16'h0002, 16'h0005);
    run_idle(40);

    // Ack arriving on the timeout edge.
    force_ack_at = TMO;
    push_wait(16'h0004, 16'h00FF);
    run_idle(25);

    // Burst behind a slow transaction: fills the FIFO, last push stalls.
    force_ack_at = 12;
    push_wait(16'h0008, 16'h0001);
    push_wait(16'h0002, 16'h0004);
    push_wait(16'h0004, 16'h00FF);
    push_wait(16'h0006, 16'h0080);
    push_wait(16'h0000, 16'h0016);
    push_wait(16'h000A, 16'h0033);
    run_idle(60);

    // Random traffic with random slave latency and spurious idle acks.
    repeat (1500) begin
      cmd_valid = 1'($urandom_range(1));
      cmd_adr   = 16'($urandom);
      cmd_data  = 16'($urandom);
      cycle(p);
    end
    run_idle(80);

    // Asynchronous reset while a write is on the bus with two queued behind it.
    force_ack_at = TMO + 50;
    push_wait(16'h00A0, 16'h1111);
    push_wait(16'h00A2, 16'h2222);
    push_wait(16'h00A4, 16'h3333);
    guard = 0;
    while (!(m_bus && exp_q.size() >= 2) && guard < 20) begin
      cycle(p);
      guard++;
    end
    check("pre_reset_state", {31'd0, m_bus && exp_q.size() >= 2}, 1);
    #2 rst_n = 1'b0;
    wb_ack = 1'b0;
    #1;
    model_reset();
    check("async_cyc", wb_cyc, 0);
    check("async_stb", wb_stb, 0);
    check("async_we", wb_we, 0);
    check("async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", cmd_ready, 1);
    drive_ack();
    run_idle(20);

    // Recovery after reset.
    force_ack_at = 2;
    push_wait(16'h0010, 16'hBEEF);
    run_idle(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
